// File: rtl/sequenced_decoder_5_32.sv
// Registered 5:32 one-hot decoder with valid/ready intake.
// Ports: Clock_In, Reset_In (async high), Enable_In, Valid_In,
//   Encoded_Value_In[4:0] -> Ready_Out, Decoded_Value_Out[31:0],
//   Active_Out, Done_Out.
module sequenced_decoder_5_32 #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int COUNT_WIDTH = 8
) (
  input  logic        Clock_In,
  input  logic        Reset_In,
  input  logic        Enable_In,
  input  logic        Valid_In,
  input  logic [4:0]  Encoded_Value_In,
  output logic        Ready_Out,
  output logic [31:0] Decoded_Value_Out,
  output logic        Active_Out,
  output logic        Done_Out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_GAP
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] HOLD_LD =
    COUNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] GAP_LD =
    COUNT_WIDTH'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  localparam logic [COUNT_WIDTH-1:0] ONE =
    COUNT_WIDTH'(1);

  state_t                 r_state;
  state_t                 w_state_n;
  logic [COUNT_WIDTH-1:0] r_cnt;
  logic [COUNT_WIDTH-1:0] w_cnt_n;
  logic [31:0]            r_dec;
  logic [31:0]            w_dec_n;
  logic                   r_act;
  logic                   r_done;
  logic                   w_last;
  logic                   w_ready;
  logic                   w_accept;
  logic [31:0]            w_onehot;

  assign w_last   = (r_cnt == '0);
  assign w_accept = Valid_In && w_ready;
  assign w_onehot = 32'd1 << Encoded_Value_In;

  always_comb begin
    w_ready = 1'b0;
    unique case (r_state)
      S_IDLE:  w_ready = Enable_In;
      S_DRIVE: w_ready = Enable_In && w_last &&
                         (GAP_CYCLES == 0);
      S_GAP:   w_ready = Enable_In && w_last;
      default: w_ready = 1'b0;
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_n = S_DRIVE;
          w_cnt_n   = HOLD_LD;
        end
      end
      S_DRIVE: begin
        if (!Enable_In) begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
        end else if (!w_last) begin
          w_cnt_n = r_cnt - ONE;
        end else if (GAP_CYCLES > 0) begin
          w_state_n = S_GAP;
          w_cnt_n   = GAP_LD;
        end else if (w_accept) begin
          w_state_n = S_DRIVE;
          w_cnt_n   = HOLD_LD;
        end else begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
        end
      end
      S_GAP: begin
        if (!Enable_In) begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
        end else if (!w_last) begin
          w_cnt_n = r_cnt - ONE;
        end else if (w_accept) begin
          w_state_n = S_DRIVE;
          w_cnt_n   = HOLD_LD;
        end else begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = '0;
      end
    endcase
  end

  // A new accept replaces the line outright, so back-to-back
  // codes never overlap and never produce a zero cycle.
  always_comb begin
    w_dec_n = '0;
    if (w_accept)
      w_dec_n = w_onehot;
    else if (w_state_n == S_DRIVE)
      w_dec_n = r_dec;
  end

  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dec   <= '0;
      r_act   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_dec   <= w_dec_n;
      r_act   <= (w_state_n == S_DRIVE);
      r_done  <= (w_state_n == S_DRIVE) &&
                 (w_cnt_n == '0);
    end
  end

  assign Ready_Out         = w_ready;
  assign Decoded_Value_Out = r_dec;
  assign Active_Out        = r_act;
  // Dropping enable on the final hold cycle aborts it, so the
  // completion pulse is masked in that same cycle.
  assign Done_Out          = r_done && Enable_In;

endmodule
